// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants for the MIPS-style front end.
// Holds the default reset PC, the halt encoding and the prefetch entry layout.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [XLEN-1:0] HALT_INSTR       = 32'hFC00_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO of {instr, pc} entries between instruction memory and decode.
// Flush empties it in one cycle and overrides any push or pop in that cycle.
module ifu_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           push_data,
  output fetch_entry_t           head,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && !flush && (count_q != '0);
    do_push  = push && !flush && ((count_q != FULL) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head outputs read as zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: fetch PC, single-outstanding memory reads, prefetch FIFO to decode.
// Optional halt detection is enabled by defining IFETCH_HALT_DETECT_EN.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  output logic            fetch_err,
  output logic            halted
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            outstanding_q, outstanding_d;
  logic            discard_q, discard_d;
  logic            fetch_err_q, fetch_err_d;
  logic            halted_q, halted_d;

  logic            req_fire, resp_fire, resp_keep, halt_hit, fifo_pop;
  logic [CW-1:0]   fifo_count, inflight;
  fetch_entry_t    fifo_head, push_entry;

  // The outstanding slot counts against capacity so a returning word always has room.
  assign inflight  = fifo_count + CW'(outstanding_q);
  assign req_fire  = !rst && !outstanding_q && !halted_q && !redirect_valid && (inflight < DEPTH_C);
  assign resp_fire = imem_rvalid && outstanding_q;
  assign resp_keep = resp_fire && !discard_q && !redirect_valid;
  assign fifo_pop  = instr_valid && instr_ready && !redirect_valid;

  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = req_pc_q;

`ifdef IFETCH_HALT_DETECT_EN
  assign halt_hit = resp_keep && (imem_rdata == HALT_INSTR);
`else
  assign halt_hit = 1'b0;
`endif

  // A redirect retargets the PC and marks any still-pending response as stale.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    halted_d      = halted_q | halt_hit;
    fetch_err_d   = redirect_valid && (redirect_pc[1:0] != 2'b00);
    if (resp_fire) begin
      outstanding_d = 1'b0;
      discard_d     = 1'b0;
    end
    if (redirect_valid) begin
      fetch_pc_d = align_word(redirect_pc);
      if (outstanding_q && !imem_rvalid) discard_d = 1'b1;
    end else if (req_fire) begin
      fetch_pc_d    = fetch_pc_q + 32'd4;
      req_pc_d      = fetch_pc_q;
      outstanding_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      fetch_err_q   <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fetch_err_q   <= fetch_err_d;
      halted_q      <= halted_d;
    end
  end

  ifu_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (resp_keep),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .push_data (push_entry),
    .head      (fifo_head),
    .head_valid(instr_valid),
    .count     (fifo_count)
  );

  assign imem_req  = req_fire;
  assign imem_addr = req_fire ? fetch_pc_q : '0;
  assign instr     = fifo_head.instr;
  assign instr_pc  = fifo_head.pc;
  assign fetch_err = fetch_err_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized traffic
// checked against a transaction-level model of the fetch stream and memory.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam int          DEPTH     = 2;
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fetch_err;
  logic        halted;

  ifetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fetch_err(fetch_err), .halted(halted)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: words buffered for decode, next expected pcs, pending memory read.
  int          occ;
  logic [31:0] expPc, expReqPc;
  bit          haltSeen, errPending;
  bit          pendValid;
  int          pendDelay, pendEpoch, epoch;
  logic [31:0] pendAddr;
  int          latMin = 1, latMax = 1;
  bit          haltAddrEn = 0;
  logic [31:0] haltAddr = '0;
  bit          prevHold;
  logic [31:0] prevInstr, prevPc;

  // Per-cycle observations for the directed scenarios.
  bit          sawReq, sawValid, sawErr, sawHalted, sawConsume;
  logic [31:0] sawAddr, sawConsumePc;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] w;
    if (haltAddrEn && a == haltAddr) return HALT_WORD;
    w = (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    if (w == HALT_WORD) w = w ^ 32'h1;
    return w;
  endfunction

  task automatic modelReset();
    occ        = 0;
    expPc      = RESET_PC;
    expReqPc   = RESET_PC;
    haltSeen   = 0;
    errPending = 0;
    pendValid  = 0;
    epoch      = 0;
    prevHold   = 0;
    imem_rvalid = 0;
    imem_rdata  = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    imem_rvalid = 0;
    imem_rdata = '0;
    redirect_valid = 0;
    redirect_pc = '0;
    instr_ready = 0;
    repeat (2) @(posedge clk);
    #3;
    tests++;
    if ({imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err, halted} !== 100'd0)
      begin
        fails++;
        $display("[TB] FAIL reset_outputs req=%b addr=%h v=%b instr=%h pc=%h err=%b halt=%b, want all 0",
                 imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err, halted);
      end
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  // One clock: inputs are already driven; check outputs mid-cycle, then advance model and memory.
  task automatic cycle();
    bit          expReq, consume, deliver;
    logic [31:0] deliverData, rp;
    bit          rv;
    #2;
    sawConsume = 0;
    expReq = !pendValid && (occ < DEPTH) && !haltSeen && !redirect_valid;
    tests++;
    if (imem_req !== expReq) begin
      fails++;
      $display("[TB] FAIL req_gate t=%0t got %b want %b", $time, imem_req, expReq);
    end
    if (imem_req && expReq) begin
      tests++;
      if (imem_addr !== expReqPc) begin
        fails++;
        $display("[TB] FAIL req_addr t=%0t got %h want %h", $time, imem_addr, expReqPc);
      end
    end
    tests++;
    if (instr_valid !== (occ > 0)) begin
      fails++;
      $display("[TB] FAIL instr_valid t=%0t got %b want %b", $time, instr_valid, occ > 0);
    end
    tests++;
    if (fetch_err !== errPending) begin
      fails++;
      $display("[TB] FAIL fetch_err t=%0t got %b want %b", $time, fetch_err, errPending);
    end
    tests++;
    if (halted !== haltSeen) begin
      fails++;
      $display("[TB] FAIL halted t=%0t got %b want %b", $time, halted, haltSeen);
    end
    if (prevHold && instr_valid) begin
      tests++;
      if (instr !== prevInstr || instr_pc !== prevPc) begin
        fails++;
        $display("[TB] FAIL hold_stable t=%0t got %h@%h want %h@%h", $time, instr, instr_pc, prevInstr, prevPc);
      end
    end
    consume = instr_valid && instr_ready && !redirect_valid;
    if (consume) begin
      tests++;
      if (instr_pc !== expPc || instr !== memWord(expPc)) begin
        fails++;
        $display("[TB] FAIL consume t=%0t got %h@%h want %h@%h", $time, instr, instr_pc, memWord(expPc), expPc);
      end
      sawConsume   = 1;
      sawConsumePc = instr_pc;
    end
    sawReq      = imem_req;
    sawAddr     = imem_addr;
    sawValid    = instr_valid;
    sawErr      = fetch_err;
    sawHalted   = halted;
    deliver     = imem_rvalid;
    deliverData = imem_rdata;
    rv          = redirect_valid;
    rp          = redirect_pc;
    prevHold    = instr_valid && !instr_ready && !redirect_valid;
    prevInstr   = instr;
    prevPc      = instr_pc;

    @(posedge clk);
    #1;

    if (deliver) pendValid = 0;
    if (rv) begin
      occ      = 0;
      expPc    = {rp[31:2], 2'b00};
      expReqPc = {rp[31:2], 2'b00};
      epoch++;
    end else begin
      if (deliver && pendEpoch == epoch) begin
        occ++;
`ifdef IFETCH_HALT_DETECT_EN
        if (deliverData == HALT_WORD) haltSeen = 1;
`endif
      end
      if (consume) begin
        occ--;
        expPc = expPc + 32'd4;
      end
      if (sawReq) begin
        expReqPc  = expReqPc + 32'd4;
        pendValid = 1;
        pendAddr  = sawAddr;
        pendEpoch = epoch;
        pendDelay = int'($urandom_range(latMax, latMin));
      end
    end
    errPending = rv && (rp[1:0] != 2'b00);

    imem_rvalid = 0;
    if (pendValid) begin
      pendDelay--;
      if (pendDelay == 0) begin
        imem_rvalid = 1;
        imem_rdata  = memWord(pendAddr);
      end
    end
  endtask

  task automatic test_reset();
    doReset();
  endtask

  task automatic test_startup();
    logic [31:0] reqs[$];
    int firstValid = -1;
    latMin = 1; latMax = 1;
    instr_ready = 1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (sawReq) reqs.push_back(sawAddr);
      if (sawValid && firstValid < 0) firstValid = i;
    end
    tests++;
    if (firstValid != 2) begin
      fails++;
      $display("[TB] FAIL first_valid_latency got %0d want 2", firstValid);
    end
    tests++;
    if (reqs.size() < 3 || reqs[0] !== 32'h3000 || reqs[1] !== 32'h3004 || reqs[2] !== 32'h3008) begin
      fails++;
      $display("[TB] FAIL startup_addrs got %0d reqs first=%h want 3000,3004,3008",
               reqs.size(), (reqs.size() > 0) ? reqs[0] : 32'hX);
    end
  endtask

  task automatic test_stall();
    int lateReqs = 0, nCons = 0, nReq = 0;
    instr_ready = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i >= 5 && sawReq) lateReqs++;
    end
    tests++;
    if (lateReqs != 0 || !sawValid) begin
      fails++;
      $display("[TB] FAIL stall_saturate reqs=%0d valid=%b want 0 reqs, valid 1", lateReqs, sawValid);
    end
    instr_ready = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (sawConsume) nCons++;
      if (sawReq) nReq++;
    end
    tests++;
    if (nCons < 2 || nReq == 0) begin
      fails++;
      $display("[TB] FAIL stall_drain consumed=%0d reqs=%0d want >=2 and >0", nCons, nReq);
    end
  endtask

  task automatic test_redirect();
    bit found = 0, got = 0;
    logic [31:0] pc = '0;
    latMin = 3; latMax = 3;
    instr_ready = 1;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (sawReq) found = 1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("[TB] FAIL redirect_setup got no request want one within 20 cycles");
    end
    redirect_valid = 1;
    redirect_pc = 32'h0000_3100;
    cycle();
    redirect_valid = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      if (sawConsume) begin
        got = 1;
        pc = sawConsumePc;
      end
    end
    tests++;
    if (!got || pc !== 32'h0000_3100) begin
      fails++;
      $display("[TB] FAIL redirect_target got=%b pc=%h want pc 00003100", got, pc);
    end
  endtask

  task automatic test_misaligned();
    int nErr = 0;
    bit gotReq = 0;
    logic [31:0] firstReq = '0;
    latMin = 1; latMax = 1;
    redirect_valid = 1;
    redirect_pc = 32'h0000_3102;
    cycle();
    redirect_valid = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (sawErr) nErr++;
      if (sawReq && !gotReq) begin
        gotReq = 1;
        firstReq = sawAddr;
      end
    end
    tests++;
    if (nErr != 1) begin
      fails++;
      $display("[TB] FAIL fetch_err_pulse got %0d cycles want 1", nErr);
    end
    tests++;
    if (!gotReq || firstReq !== 32'h0000_3100) begin
      fails++;
      $display("[TB] FAIL misaligned_target got=%b addr=%h want 00003100", gotReq, firstReq);
    end
  endtask

  task automatic test_halt();
    int reqAfterHalt = 0, reqPostRedirect = 0;
    bit haltObs = 0, haltCons = 0, haltStill = 1;
    doReset();
    haltAddrEn = 1;
    haltAddr = RESET_PC + 32'd8;
    latMin = 1; latMax = 1;
    instr_ready = 1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (sawHalted) begin
        haltObs = 1;
        if (sawReq) reqAfterHalt++;
      end
      if (sawConsume && sawConsumePc == haltAddr) haltCons = 1;
    end
    redirect_valid = 1;
    redirect_pc = 32'h0000_3200;
    cycle();
    redirect_valid = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (sawReq) reqPostRedirect++;
      if (!sawHalted) haltStill = 0;
    end
`ifdef IFETCH_HALT_DETECT_EN
    tests++;
    if (!haltObs || reqAfterHalt != 0 || !haltCons) begin
      fails++;
      $display("[TB] FAIL halt_detect halted=%b reqs_after=%0d consumed=%b want 1,0,1", haltObs, reqAfterHalt, haltCons);
    end
    tests++;
    if (!haltStill || reqPostRedirect != 0) begin
      fails++;
      $display("[TB] FAIL halt_sticky halted=%b reqs=%0d want 1,0", haltStill, reqPostRedirect);
    end
`else
    tests++;
    if (haltObs || !haltCons) begin
      fails++;
      $display("[TB] FAIL halt_disabled halted=%b consumed=%b want 0,1", haltObs, haltCons);
    end
    tests++;
    if (reqPostRedirect == 0) begin
      fails++;
      $display("[TB] FAIL halt_disabled_fetch got %0d reqs want >0", reqPostRedirect);
    end
`endif
    doReset();
    haltAddrEn = 0;
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] reqs[$];
    bit found = 0;
    latMin = 1; latMax = 1;
    instr_ready = 1;
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (sawReq) reqs.push_back(sawAddr);
    end
    tests++;
    if (reqs.size() < 2 || reqs[0] !== 32'hFFFF_FFFC || reqs[1] !== 32'h0000_0000) begin
      fails++;
      $display("[TB] FAIL pc_wrap got %0d reqs first=%h want FFFFFFFC then 00000000",
               reqs.size(), (reqs.size() > 0) ? reqs[0] : 32'hX);
    end
    latMin = 2; latMax = 2;
    instr_ready = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (sawReq) found = 1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("[TB] FAIL reset_mid_setup got no request want one within 20 cycles");
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_mid_response valid=%b req=%b want 0,0", instr_valid, imem_req);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    instr_ready = 1;
    latMin = 1; latMax = 1;
    cycle();
    tests++;
    if (sawValid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_fifo_empty got valid=%b want 0", sawValid);
    end
    for (int i = 0; i < 6; i++) cycle();
  endtask

  task automatic test_random();
    doReset();
    latMin = 1; latMax = 3;
    for (int i = 0; i < 600; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        redirect_valid = 1;
        if ($urandom_range(0, 3) == 0)
          redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else
          redirect_pc = 32'h0000_4000 + 32'($urandom_range(0, 4095));
      end else begin
        redirect_valid = 0;
      end
      cycle();
    end
    redirect_valid = 0;
  endtask

  initial begin
    rst = 1'b1;
    imem_rvalid = 0;
    imem_rdata = '0;
    redirect_valid = 0;
    redirect_pc = '0;
    instr_ready = 0;
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_misaligned();
    test_halt();
    test_wrap_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
